// File: rtl/muldiv_riscv.sv
// ----------------------------------------------------------------------------
// muldiv_riscv
//
// Iterative RISC-V "M"-extension arithmetic unit. It accepts one multiply or
// divide/remainder request through a valid/ready handshake. It returns the
// result with a single-cycle valid_o pulse. The op code is the RV32M funct3
// value, so the decoder can forward funct3 unchanged.
//
// Multiplies take WIDTH shift-add steps. Divides use a restoring algorithm
// with one quotient bit per step. Divide-by-zero and signed overflow are
// resolved at acceptance and skip the iteration entirely.
//
// Build option:
//   MULDIV_DIV_EN  defined   -> full unit, including the divider datapath.
//                  undefined -> divider compiled out. Ops 100..111 complete
//                               in one cycle with result 0.
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   valid_i   request strobe, only looked at while ready_o=1
//   ready_o   unit idle and able to accept a request
//   op_i      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a_i       operand rs1
//   b_i       operand rs2
//   valid_o   one-cycle pulse marking result_o as fresh
//   result_o  result, held until the next completion
// ----------------------------------------------------------------------------
module muldiv_riscv #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2:0]           op_q, op_d;
   logic                 negA_q, negA_d;
   logic                 negB_q, negB_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 signedA;
   logic                 signedB;
   logic                 negA;
   logic                 negB;
   logic [WIDTH-1:0]     absA;
   logic [WIDTH-1:0]     absB;

   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [2*WIDTH-1:0]   mulFix;
   logic [WIDTH-1:0]     mulResult;

   logic [2*WIDTH-1:0]   divNext;
   logic [WIDTH-1:0]     divResult;
   logic [WIDTH-1:0]     finalResult;

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH+1:0]     remShift;
   logic [WIDTH+1:0]     remDiff;
   logic [WIDTH:0]       remNext;
   logic [WIDTH-1:0]     remLow;
   logic [WIDTH-1:0]     quoNext;
   logic [WIDTH-1:0]     quoFix;
   logic [WIDTH-1:0]     remFix;
   logic                 divByZero;
   logic                 divOverflow;
`endif

   // Operand conditioning at acceptance. MULH, DIV and REM treat both
   // operands as signed. MULHSU treats only rs1 as signed. Signed operands
   // become magnitudes here, so the iterative datapath only ever works on
   // unsigned values. The recorded signs are fixed up at the end.
   assign signedA = op_i[2] ? ~op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
   assign signedB = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
   assign negA    = signedA & a_i[WIDTH-1];
   assign negB    = signedB & b_i[WIDTH-1];
   assign absA    = negA ? -a_i : a_i;
   assign absB    = negB ? -b_i : b_i;

   // Multiply step. The low half of the accumulator starts as the multiplier.
   // Each step adds the multiplicand into the high half when the current
   // multiplier bit is set. The whole WIDTH+1-bit sum is then shifted right,
   // so the carry is never lost. After WIDTH steps the accumulator holds the
   // full unsigned product. The sign fix is a full 2*WIDTH negate, which
   // keeps the high half correct for MULH/MULHSU.
   assign mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mulNext   = {mulSum, acc_q[WIDTH-1:1]};
   assign mulFix    = (negA_q ^ negB_q) ? -mulNext : mulNext;
   assign mulResult = (op_q[1:0] == 2'b00) ? mulFix[WIDTH-1:0] : mulFix[2*WIDTH-1:WIDTH];

`ifdef MULDIV_DIV_EN
   // Restoring divide step. The dividend sits in the low half of the
   // accumulator. Its MSB is shifted into the partial remainder each step,
   // and the new quotient bit enters at the LSB. The trial subtraction is
   // one bit wider than the remainder register, so its top bit is the
   // borrow. A borrow means the shifted remainder is kept (restored).
   assign divByZero   = (b_i == {WIDTH{1'b0}});
   assign divOverflow = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == {WIDTH{1'b1}});
   assign remShift    = {rem_q, acc_q[WIDTH-1]};
   assign remDiff     = remShift - {2'b00, opnd_q};
   assign remNext     = remDiff[WIDTH+1] ? remShift[WIDTH:0] : remDiff[WIDTH:0];
   assign quoNext     = {acc_q[WIDTH-2:0], ~remDiff[WIDTH+1]};
   assign divNext     = {acc_q[2*WIDTH-1:WIDTH], quoNext};
   assign remLow      = remNext[WIDTH-1:0];
   assign quoFix      = (negA_q ^ negB_q) ? -quoNext : quoNext;
   assign remFix      = negA_q ? -remLow : remLow;
   assign divResult   = op_q[1] ? remFix : quoFix;
`else
   // Without the divider, division ops never enter CALC. These placeholders
   // keep the shared result mux intact.
   assign divNext     = acc_q;
   assign divResult   = {WIDTH{1'b0}};
`endif

   // Final result, sampled on the last CALC step. It is built from the
   // values the last step produces, so result_o is registered on the same
   // edge that enters DONE, and valid_o is asserted during DONE.
   assign finalResult = op_q[2] ? divResult : mulResult;

   // State register and datapath registers. Reset abandons any operation in
   // flight and returns the unit to idle with a cleared result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         negA_q   <= 1'b0;
         negB_q   <= 1'b0;
         result_q <= '0;
`ifdef MULDIV_DIV_EN
         rem_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         negA_q   <= negA_d;
         negB_q   <= negB_d;
         result_q <= result_d;
`ifdef MULDIV_DIV_EN
         rem_q    <= rem_d;
`endif
      end
   end

   // Next-state logic. IDLE latches a request and its conditioned operands.
   // Special-case divides are resolved right away and jump straight to DONE.
   // CALC runs one step per cycle until the counter runs out. DONE lasts
   // exactly one cycle and marks the valid_o pulse. Requests arriving
   // outside IDLE are simply not looked at.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      negA_d   = negA_q;
      negB_d   = negB_q;
      result_d = result_q;
`ifdef MULDIV_DIV_EN
      rem_d    = rem_q;
`endif

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               op_d    = op_i;
               negA_d  = negA;
               negB_d  = negB;
               count_d = CW'(WIDTH);
               if (op_i[2]) begin
`ifdef MULDIV_DIV_EN
                  acc_d  = {{WIDTH{1'b0}}, absA};
                  opnd_d = absB;
                  rem_d  = '0;
                  if (divByZero) begin
                     result_d = op_i[1] ? a_i : {WIDTH{1'b1}};
                     state_d  = DONE;
                  end else if (divOverflow && !op_i[0]) begin
                     result_d = op_i[1] ? {WIDTH{1'b0}} : a_i;
                     state_d  = DONE;
                  end else begin
                     state_d  = CALC;
                  end
`else
                  result_d = {WIDTH{1'b0}};
                  state_d  = DONE;
`endif
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, absB};
                  opnd_d  = absA;
                  state_d = CALC;
               end
            end
         end

         CALC: begin
            count_d = count_q - CW'(1);
            if (op_q[2]) begin
               acc_d = divNext;
`ifdef MULDIV_DIV_EN
               rem_d = remNext;
`endif
            end else begin
               acc_d = mulNext;
            end
            if (count_q == CW'(1)) begin
               result_d = finalResult;
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_riscv.sv
// ----------------------------------------------------------------------------
// tb_muldiv_riscv
//
// Self-checking bench for muldiv_riscv at WIDTH=32. It runs four groups:
//   - a directed vector table with latency checks,
//   - a reset applied mid-calculation,
//   - a continuously held valid_i with changing operands,
//   - randomized requests checked against an arithmetic reference model.
// Expected division results follow the MULDIV_DIV_EN build option.
// ----------------------------------------------------------------------------
module tb_muldiv_riscv;

   localparam int W = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DIVON = 1'b1;
`else
   localparam bit DIVON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          validIn;
   logic          ready;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          validOut;
   logic [W-1:0]  result;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
      string        name;
   } vec_t;

   vec_t vecs[$];

   muldiv_riscv #(.WIDTH(W)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (validIn),
      .ready_o  (ready),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .valid_o  (validOut),
      .result_o (result)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Watchdog so that a stuck handshake can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model. It uses plain 64-bit arithmetic and SystemVerilog
   // division, plus the RISC-V rules for division by zero and overflow.
   function automatic void modelOp(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output logic [W-1:0] r,
                                   output int lat);
      logic [63:0] p;
      longint      sx;
      longint      sy;
      longint      uy;
      int          ix;
      int          iy;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      uy  = longint'({32'b0, y});
      ix  = x;
      iy  = y;
      lat = W + 1;
      r   = '0;
      case (o)
         3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0];  end
         3'd1: begin p = sx * sy;                 r = p[63:32]; end
         3'd2: begin p = sx * uy;                 r = p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
         default: begin
            if (!DIVON) begin
               r   = '0;
               lat = 1;
            end else if (y == 0) begin
               r   = o[1] ? x : 32'hFFFF_FFFF;
               lat = 1;
            end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r   = o[1] ? 32'h0 : x;
               lat = 1;
            end else if (!o[0]) begin
               r = o[1] ? (ix % iy) : (ix / iy);
            end else begin
               r = o[1] ? (x % y) : (x / y);
            end
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Issues one request. The caller must be positioned at a falling edge.
   // Returns the result, the latency in cycles after the accept edge, and
   // ready_o just after acceptance and just after the valid_o cycle.
   task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output int lat,
                                output logic rdyBusy, output logic rdyBack);
      int n;
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      validIn = 1'b1;
      op      = o;
      a       = x;
      b       = y;
      @(posedge clk);
      @(negedge clk);
      validIn = 1'b0;
      op      = 3'($urandom);
      a       = $urandom;
      b       = $urandom;
      rdyBusy = ready;
      lat     = 1;
      while (!validOut && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!validOut) lat = -1;
      r = result;
      @(negedge clk);
      rdyBack = ready;
   endtask

   task automatic runVec(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] expR, input int expLat);
      logic [W-1:0] r;
      int           lat;
      logic         rb;
      logic         rk;
      applyStimulus(o, x, y, r, lat, rb, rk);
      checkOutput({name, "_result"}, r, expR);
      checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_busy"}, {31'b0, rb}, 32'd0);
      checkOutput({name, "_readyback"}, {31'b0, rk}, 32'd1);
   endtask

   task automatic addVec(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] expR, input int expLat);
      vec_t v;
      v.op   = o;
      v.a    = x;
      v.b    = y;
      v.exp  = expR;
      v.lat  = expLat;
      v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic [W-1:0] e;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [2:0]   o;
      int           l;
      int           pulses;
      int           accepts;
      logic [W-1:0] expQ[$];

      rst     = 1'b1;
      validIn = 1'b0;
      op      = '0;
      a       = '0;
      b       = '0;

      addVec("mul_neg1x2",     3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 33);
      addVec("mulh_m1xm1",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      addVec("mulhu_max",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      addVec("mulhsu_m1",      3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      addVec("mul_7x6",        3'd0, 32'd7,         32'd6,         32'd42,        33);
      addVec("div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,  DIVON ? 32'hFFFF_FFFD : 32'h0, DIVON ? 33 : 1);
      addVec("rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,  DIVON ? 32'hFFFF_FFFF : 32'h0, DIVON ? 33 : 1);
      addVec("divu_big",       3'd5, 32'h8000_0000, 32'd2,  DIVON ? 32'h4000_0000 : 32'h0, DIVON ? 33 : 1);
      addVec("remu_10_3",      3'd7, 32'd10,        32'd3,  DIVON ? 32'd1 : 32'h0,         DIVON ? 33 : 1);
      addVec("div_by_zero",    3'd4, 32'd5,         32'd0,  DIVON ? 32'hFFFF_FFFF : 32'h0, 1);
      addVec("remu_by_zero",   3'd7, 32'd5,         32'd0,  DIVON ? 32'd5 : 32'h0,         1);
      addVec("div_overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIVON ? 32'h8000_0000 : 32'h0, 1);
      addVec("rem_overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      addVec("divu_10_3",      3'd5, 32'd10,        32'd3,  DIVON ? 32'd3 : 32'h0,         DIVON ? 33 : 1);
      addVec("mul_3x5",        3'd0, 32'd3,         32'd5,         32'd15,        33);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_ready",  {31'b0, ready},    32'd1);
      checkOutput("reset_valid",  {31'b0, validOut}, 32'd0);
      checkOutput("reset_result", result,            32'd0);

      $display("[TB] directed vector table");
      foreach (vecs[i]) begin
         runVec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      $display("[TB] reset during calculation");
      validIn = 1'b1;
      op      = 3'd0;
      a       = 32'd7;
      b       = 32'd6;
      @(posedge clk);
      @(negedge clk);
      validIn = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midcalc_result_held", result, 32'd15);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midreset_ready",  {31'b0, ready},    32'd1);
      checkOutput("midreset_valid",  {31'b0, validOut}, 32'd0);
      checkOutput("midreset_result", result,            32'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (validOut) pulses++;
         @(negedge clk);
      end
      checkOutput("midreset_no_pulse", 32'(pulses), 32'd0);
      runVec("after_reset_mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      $display("[TB] held valid_i handshake");
      pulses  = 0;
      accepts = 0;
      validIn = 1'b1;
      for (int c = 0; c < 260; c++) begin
         if (validOut) begin
            pulses++;
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               checkOutput("hs_result", result, e);
            end else begin
               checkOutput("hs_spurious_pulse", 32'(pulses), 32'(accepts));
            end
         end
         if (c < 200) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            op = o;
            a  = x;
            b  = y;
            if (ready) begin
               modelOp(o, x, y, e, l);
               expQ.push_back(e);
               accepts++;
            end
         end else begin
            validIn = 1'b0;
         end
         @(negedge clk);
      end
      checkOutput("hs_pulse_count", 32'(pulses), 32'(accepts));

      $display("[TB] randomized requests");
      for (int k = 0; k < 150; k++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 9))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 15));
            3: x = 32'hFFFF_FFFF;
            default: ;
         endcase
         modelOp(o, x, y, e, l);
         runVec("random", o, x, y, e, l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
